seg_serial_driver: RTL and testbench
====================================

Name: seg_serial_driver

Overview:
- Display back-end inside `top` that feeds the board's serial 7-segment chain (74HC164-style shift registers) through SEGCLK/SEGDT/SEGEN/SEGCLR.
- Takes an 8-digit hex value (score/timer from game logic) and decimal-point mask, encodes each digit to active-low segments, and shifts 64 bits out serially.
- Refreshes on request and periodically.

Parameters:
- DIV, 2, SEGCLK half-period in clk cycles (>=1).
- REFRESH, 1_000_000, clk cycles between automatic refreshes (0 disables).

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous reset, active-low
- data  in  32  eight hex digits; data[31:28] is digit 7 (leftmost)
- point  in  8  decimal-point enable, point[i] for digit i, 1 = lit
- update  in  1  one-cycle refresh request
- busy  out  1  high while a frame is being shifted
- SEGCLK  out  1  serial shift clock (shift on rising edge)
- SEGDT  out  1  serial data
- SEGEN  out  1  chain output enable
- SEGCLR  out  1  chain clear, active-low

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE, busy=0, SEGCLK=0, SEGDT=0, SEGEN=0, SEGCLR=0, pending=0, refresh counter=0.
  - Reset mid-frame aborts immediately with these values.
- After reset SEGCLR=1 and SEGEN=1 permanently. A pending=1 is forced so the first frame goes out without a request.
- Encoding per digit:
  - byte = {~point[i], g,f,e,d,c,b,a}, segments active-low.
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values shown with point=0).
- Frame order: 64 bits, digit 7 first, MSB (dp) first within each byte.
- FSM:
  - IDLE: if update|pending|refresh_tick, go to LOAD and clear pending.
  - LOAD (1 cycle): snapshot data/point into a 64-bit encoded shift register; bit counter=63; SEGDT=bit 63; SEGCLK=0; busy=1.
  - SHIFT_LO: SEGCLK=0 for DIV cycles, then go to SHIFT_HI.
  - SHIFT_HI: SEGCLK=1 for DIV cycles. At exit:
    - counter=0 goes to DONE.
    - Otherwise shift left, counter-1, SEGDT=next bit, go to SHIFT_LO.
  - DONE (1 cycle): SEGCLK=0, SEGDT=0, busy=0, then IDLE.
- SEGDT changes only while SEGCLK=0, and is stable for the full SEGCLK high phase.
- busy rises on the cycle after the request is accepted. Frame latency from accept to busy=0 is 2 + 64*2*DIV cycles (258 at DIV=2).
- Inputs are sampled only in LOAD. Changes to data/point during a frame do not affect the frame in flight.
- update or refresh_tick while not IDLE sets pending. Multiple requests collapse into one pending frame, which starts immediately after DONE.
- Refresh counter:
  - Counts 0..REFRESH-1 continuously; refresh_tick=1 at wrap.
  - Counter is 32 bits, wrapping at REFRESH-1.
- Simultaneous update and refresh_tick in IDLE produce one frame.

Decomposition:
- Package seg_pkg holds:
  - state enum (IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE);
  - 16-entry hex-to-segment constant table;
  - FRAME_BITS=64.
- One combinational sub-module `hex_to_seg7` (4-bit nibble + dp, to 8-bit active-low byte), instantiated 8 times.
- Shifter FSM and counters stay in the top of this block.

Test Plan:
1. Hold rstn=0 for 5 cycles, then release (DIV=2, REFRESH=0) -> all outputs 0 during reset. SEGCLR=SEGEN=1 after release. One frame starts automatically. busy=1 for exactly 257 cycles.
2. data=32'h0123_4567, point=0, update pulse -> captured 64 SEGDT samples at SEGCLK rising edges = C0,F9,A4,B0,99,92,82,F8. Each SEGCLK high = 2 cycles, low = 2 cycles.
3. data=32'hFFFF_FFFF, point=8'h81 -> bytes 0E,8E,8E,8E,8E,8E,8E,0E. Changing data to 0 mid-frame leaves the frame unchanged.
4. Three update pulses during busy -> exactly one extra frame, starting the cycle after DONE. No third frame follows.
5. REFRESH=1000, no updates -> frame starts every 1000 cycles. An update coincident with a tick gives one frame only.
6. Assert rstn=0 at bit 30 of a frame -> next cycle SEGCLK=SEGDT=busy=0. Release gives a fresh full 64-bit frame.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the serial 7-segment driver.
package seg_pkg;

  localparam int FRAME_BITS = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } seg_state_e;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first so HEX_SEG[n] is digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// One digit: hex nibble plus decimal point to an active-low segment byte.
module hex_to_seg7 (
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  import seg_pkg::*;

  // dp sits in the MSB so it is the first bit of each digit on the wire
  assign seg_o = {~dp_i, HEX_SEG[nib_i]};

endmodule

// File: rtl/seg_serial_driver.sv
// Encodes eight hex digits and shifts the 64-bit frame into a 74HC164 chain.
module seg_serial_driver #(
  parameter int DIV     = 2,
  parameter int REFRESH = 1_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data,
  input  logic [7:0]  point,
  input  logic        update,
  output logic        busy,
  output logic        SEGCLK,
  output logic        SEGDT,
  output logic        SEGEN,
  output logic        SEGCLR
);
  import seg_pkg::*;

  localparam int          DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [31:0] REF_LAST = (REFRESH > 0) ? 32'(REFRESH - 1) : 32'd0;

  seg_state_e      state_q, state_d;
  logic [63:0]     sr_q, sr_d;
  logic [5:0]      bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic [31:0]     ref_q, ref_d;
  logic            pend_q, pend_d;
  logic            init_q;
  logic            busy_q, busy_d;
  logic            sclk_q, sclk_d;
  logic            sdt_q, sdt_d;
  logic            tick, req, phase_end;
  logic [7:0][7:0] enc;

  // Digit 7 lands in enc[7], i.e. the top byte of the frame
  for (genvar g = 0; g < 8; g++) begin : g_dig
    hex_to_seg7 u_dig (
      .nib_i (data[g*4 +: 4]),
      .dp_i  (point[g]),
      .seg_o (enc[g])
    );
  end

  // State and output registers; reset parks everything low, including SEGEN/SEGCLR
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      ref_q   <= '0;
      pend_q  <= 1'b0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
      init_q  <= 1'b1;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdt_q   <= sdt_d;
    end
  end

  // Next-state logic: refresh timer, request collapsing and the bit shifter
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    div_d     = div_q;
    pend_d    = pend_q;
    sdt_d     = sdt_q;
    tick      = (REFRESH != 0) && (ref_q == REF_LAST);
    ref_d     = (tick || REFRESH == 0) ? 32'd0 : ref_q + 32'd1;
    req       = update | tick;
    phase_end = (div_q == DIV_LAST);

    // requests arriving mid-frame fold into a single follow-up frame
    if (state_q != IDLE && req) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (req || pend_q) begin
          state_d = LOAD;
          pend_d  = 1'b0;
        end else if (!init_q) begin
          pend_d  = 1'b1;  // first frame after reset goes out unasked
        end
      end
      LOAD: begin
        sr_d    = enc;
        bit_d   = 6'(FRAME_BITS - 1);
        sdt_d   = enc[7][7];
        div_d   = '0;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d   = div_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          div_d = '0;
          if (bit_q == '0) begin
            sdt_d   = 1'b0;
            state_d = DONE;
          end else begin
            // data moves on the falling edge so it is settled before the next rise
            sr_d    = {sr_q[62:0], 1'b0};
            sdt_d   = sr_q[62];
            bit_d   = bit_q - 1'b1;
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    sclk_d = (state_d == SHIFT_HI);
  end

  assign busy   = busy_q;
  assign SEGCLK = sclk_q;
  assign SEGDT  = sdt_q;
  assign SEGEN  = init_q;
  assign SEGCLR = init_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Scoreboard bench: expected frames queued at request time, compared as bits arrive.
module tb_seg_serial_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, rstn_b, update, update_b;
  logic [31:0] data;
  logic [7:0]  point;
  logic        busy, sclk, sdt, sen, sclr;
  logic        busy_b, sclk_b, sdt_b, sen_b, sclr_b;

  seg_serial_driver #(.DIV(2), .REFRESH(0)) dut (
    .clk(clk), .rstn(rstn), .data(data), .point(point), .update(update),
    .busy(busy), .SEGCLK(sclk), .SEGDT(sdt), .SEGEN(sen), .SEGCLR(sclr)
  );

  seg_serial_driver #(.DIV(2), .REFRESH(1000)) dut_b (
    .clk(clk), .rstn(rstn_b), .data(data), .point(point), .update(update_b),
    .busy(busy_b), .SEGCLK(sclk_b), .SEGDT(sdt_b), .SEGEN(sen_b), .SEGCLR(sclr_b)
  );

  int checks = 0, errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [63:0] frame_of(logic [31:0] d, logic [7:0] p);
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = {~p[i], seg7(d[i*4 +: 4])};
    return f;
  endfunction

  logic [63:0] exp_q[$];

  // Monitor for dut: bit capture, phase widths, data stability, busy runs
  logic [63:0] acc;
  logic        cur_bit, prev_clk = 1'b0, prev_busy = 1'b0, seen_fall = 1'b0;
  int nbits = 0, frames_seen = 0, hi_run = 0, lo_run = 0, width_bad = 0, dt_bad = 0;
  int busy_run = 0, last_busy_len = 0, busy_rises = 0, idle_run = 0, last_gap = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      nbits = 0; prev_clk = 1'b0; hi_run = 0; lo_run = 0; seen_fall = 1'b0;
      busy_run = 0; prev_busy = 1'b0;
    end else begin
      if (sclk && !prev_clk) begin
        if (seen_fall && lo_run != 2) width_bad++;
        acc = {acc[62:0], sdt}; cur_bit = sdt; nbits++; hi_run = 1;
        if (nbits == 64) begin
          if (exp_q.size() == 0) check("sb_empty", 64'(exp_q.size()), 64'd1);
          else check("frame", acc, exp_q.pop_front());
          nbits = 0; frames_seen++;
        end
      end else if (sclk) begin
        hi_run++;
        if (sdt !== cur_bit) dt_bad++;
      end else if (prev_clk) begin
        if (hi_run != 2) width_bad++;
        seen_fall = 1'b1; lo_run = 1;
      end else begin
        lo_run++;
      end
      if (!busy) seen_fall = 1'b0;
      prev_clk = sclk;
      if (busy && !prev_busy) begin busy_rises++; last_gap = idle_run; end
      if (busy) busy_run++;
      else if (prev_busy) begin last_busy_len = busy_run; busy_run = 0; end
      if (busy) idle_run = 0; else idle_run++;
      prev_busy = busy;
    end
  end

  // Cycle stamp for dut_b frame starts
  int cyc = 0;
  always @(posedge clk) cyc++;
  int   rise_b[$];
  logic prev_busy_b = 1'b0;
  always @(negedge clk) begin
    if (busy_b && !prev_busy_b) rise_b.push_back(cyc);
    prev_busy_b = busy_b;
  end

  task automatic pulse_update();
    update = 1'b1; @(negedge clk); update = 1'b0;
  endtask

  task automatic wait_frames(int target, string tag);
    int k = 0;
    while (frames_seen < target && k < 2000) begin @(negedge clk); k++; end
    check(tag, 64'(frames_seen), 64'(target));
  endtask

  initial begin
    int r0, rr, k;
    rstn = 1'b0; rstn_b = 1'b0; update = 1'b0; update_b = 1'b0;
    data = 32'h0; point = 8'h0;

    // 1: reset values, enables after release, automatic first frame
    repeat (5) @(negedge clk);
    check("reset_outs", 64'({sclk, sdt, busy, sen, sclr}), 64'd0);
    exp_q.push_back(frame_of(32'h0, 8'h0));
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("en_clr", 64'({sen, sclr}), 64'b11);
    wait_frames(1, "auto_frame");
    repeat (4) @(negedge clk);
    check("busy_len", 64'(last_busy_len), 64'd257);

    // 2: digit table 0..7
    data = 32'h0123_4567; point = 8'h00;
    exp_q.push_back(frame_of(data, point));
    check("frame2_exp", exp_q[0], 64'hC0F9A4B0999282F8);
    pulse_update();
    wait_frames(2, "frame2_done");
    check("width_bad", 64'(width_bad), 64'd0);

    // 3: all F with two points, data changed mid-frame
    repeat (4) @(negedge clk);
    data = 32'hFFFF_FFFF; point = 8'h81;
    exp_q.push_back(64'h0E8E8E8E8E8E8E0E);
    pulse_update();
    repeat (100) @(negedge clk);
    data = 32'h0; point = 8'h0;
    wait_frames(3, "frame3_done");

    // 4: three requests while busy collapse into one extra frame
    repeat (6) @(negedge clk);
    data = 32'hDEAD_BEEF; point = 8'h3C;
    r0 = busy_rises;
    exp_q.push_back(frame_of(data, point));
    pulse_update();
    repeat (20) @(negedge clk);
    exp_q.push_back(frame_of(data, point));
    for (int i = 0; i < 3; i++) begin pulse_update(); repeat (30) @(negedge clk); end
    wait_frames(5, "frame4_done");
    repeat (4) @(negedge clk);
    check("pend_gap", 64'(last_gap), 64'd2);
    repeat (600) @(negedge clk);
    check("pend_count", 64'(busy_rises - r0), 64'd2);

    // 6: reset mid-frame aborts, release sends a fresh frame
    data = 32'h89AB_CDEF; point = 8'h55;
    exp_q.push_back(frame_of(data, point));
    pulse_update();
    k = 0;
    while (nbits < 30 && k < 1000) begin @(negedge clk); k++; end
    check("reach_bit30", 64'(nbits >= 30), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_outs", 64'({sclk, sdt, busy}), 64'd0);
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    data = 32'h1357_9BDF; point = 8'hA0;
    exp_q.push_back(frame_of(data, point));
    rstn = 1'b1;
    wait_frames(6, "fresh_frame");

    // 5: periodic refresh on the second instance
    repeat (3) @(negedge clk);
    rstn_b = 1'b1;
    k = 0;
    while (rise_b.size() < 4 && k < 5000) begin @(negedge clk); k++; end
    check("refresh_seen", 64'(rise_b.size() >= 4), 64'd1);
    if (rise_b.size() >= 4) begin
      check("refresh_int1", 64'(rise_b[2] - rise_b[1]), 64'd1000);
      check("refresh_int2", 64'(rise_b[3] - rise_b[2]), 64'd1000);
      rr = rise_b[3];
      k = 0;
      while (cyc < rr + 999 && k < 2000) begin @(negedge clk); k++; end
      update_b = 1'b1; @(negedge clk); update_b = 1'b0;
      k = 0;
      while (rise_b.size() < 6 && k < 3000) begin @(negedge clk); k++; end
      check("coinc_seen", 64'(rise_b.size() >= 6), 64'd1);
      if (rise_b.size() >= 6) begin
        check("coinc_start", 64'(rise_b[4] - rr), 64'd1000);
        check("coinc_single", 64'(rise_b[5] - rise_b[4]), 64'd1000);
      end
    end

    check("width_final", 64'(width_bad), 64'd0);
    check("dt_stable", 64'(dt_bad), 64'd0);
    check("sb_left", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
